fetch_unit: RTL and testbench

- Instruction-fetch stage that drives the single-port synchronous instruction ROM and consumes its output.
- Owns the PC register and generates the ROM address and read enable.
- Tracks the one in-flight ROM read (1-cycle latency) and presents instruction, PC, PC+4 and valid to the IF/ID boundary.
- Handles pipeline stalls, branch/jump redirects and out-of-range fetches.

---
 rtl/fetch_unit.sv | 79 +++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction ROM and
// presents the fetched word, its PC and PC+4 to the IF/ID boundary.
module fetch_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      ROM_WORDS = 256,
  parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] branch_target,
  output logic             rom_en,
  output logic [WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_rd,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             instr_valid,
  output logic             fetch_fault
);

  localparam logic [WIDTH-1:0] RomWordsW = WIDTH'(ROM_WORDS);
  localparam logic [WIDTH-1:0] PcStep    = WIDTH'(4);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] f_pc_q, f_pc_d;
  logic             f_valid_q, f_valid_d;
  logic             f_fault_q, f_fault_d;
  logic             pc_oor;
  logic             unused_tgt_lsbs;

  // Word alignment is forced, so the low target bits carry no information.
  assign unused_tgt_lsbs = ^branch_target[1:0];

  assign pc_oor = {2'b00, pc_q[WIDTH-1:2]} >= RomWordsW;

  always_comb begin
    pc_d      = pc_q;
    f_pc_d    = f_pc_q;
    f_valid_d = f_valid_q;
    f_fault_d = f_fault_q;
    if (redirect) begin
      // Squash the in-flight read; f_pc holds so instr_pc stays stable.
      pc_d      = {branch_target[WIDTH-1:2], 2'b00};
      f_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d      = pc_q + PcStep;
      f_pc_d    = pc_q;
      f_valid_d = 1'b1;
      f_fault_d = pc_oor;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      f_pc_q    <= RESET_PC;
      f_valid_q <= 1'b0;
      f_fault_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      f_pc_q    <= f_pc_d;
      f_valid_q <= f_valid_d;
      f_fault_q <= f_fault_d;
    end
  end

  // Holding rom_en low during a stall keeps the ROM output, and hence instr, stable.
  assign rom_en      = !stall && !rst;
  assign rom_addr    = pc_q;
  assign instr_valid = f_valid_q && !f_fault_q;
  assign fetch_fault = f_valid_q && f_fault_q;
  assign instr       = instr_valid ? rom_rd : NOP_INSTR;
  assign instr_pc    = f_pc_q;
  assign pc_plus4    = f_pc_q + PcStep;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural 256-word synchronous ROM.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] branch_target = '0;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_rd = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic [97:0] obs;

  fetch_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h0),
    .ROM_WORDS(256),
    .NOP_INSTR(32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .branch_target(branch_target),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_rd       (rom_rd),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .fetch_fault  (fetch_fault)
  );

  always #5 clk = ~clk;

  // Out-of-range reads return junk so a missing NOP substitution is visible.
  always @(posedge clk) begin
    if (rom_en) rom_rd <= (rom_addr[31:10] == 22'h0) ? mem[rom_addr[9:2]] : 32'hDEADBEEF;
  end

  assign obs = {instr_valid, fetch_fault, instr, instr_pc, pc_plus4};

  function automatic logic [97:0] slot(input logic v, input logic f, input logic [31:0] i,
                                       input logic [31:0] p);
    logic [31:0] p4;
    p4 = p + 32'd4;
    return {v, f, i, p, p4};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [97:0] e;
    rst = 1'b1;
    #1;
    checks++;
    if (rom_en !== 1'b0) begin
      errors++; $display("FAIL reset_rom_en: got %b want 0", rom_en);
    end
    step();
    step();
    e = slot(1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", obs, e);
    end
    checks++;
    if (rom_addr !== 32'h0) begin
      errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    logic [97:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      e = slot(1'b1, 1'b0, 32'h11 * (i + 1), 32'(4 * i));
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL free_run[%0d]: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [97:0] e;
    do_reset();
    step();
    step();
    stall = 1'b1;
    #1;
    e = slot(1'b1, 1'b0, 32'h22, 32'h4);
    checks++;
    if (rom_en !== 1'b0) begin
      errors++; $display("FAIL stall_rom_en: got %b want 0", rom_en);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== e || rom_addr !== 32'h8) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h addr %h want %h addr 8", i, obs, rom_addr, e);
      end
    end
    stall = 1'b0;
    step();
    e = slot(1'b1, 1'b0, 32'h33, 32'h8);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL stall_release: got %h want %h", obs, e);
    end
    step();
    e = slot(1'b1, 1'b0, 32'h44, 32'hC);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL stall_next: got %h want %h", obs, e);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step();
    step();
    redirect = 1'b1; branch_target = 32'h40;
    step();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || rom_addr !== 32'h40) begin
      errors++; $display("FAIL redirect_bubble: got v=%b instr=%h addr=%h want v=0 instr=0 addr=40",
                         instr_valid, instr, rom_addr);
    end
    step();
    checks++;
    if (obs !== slot(1'b1, 1'b0, 32'hAA, 32'h40)) begin
      errors++; $display("FAIL redirect_target: got %h want %h", obs, slot(1'b1, 1'b0, 32'hAA, 32'h40));
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    step();
    redirect = 1'b1; stall = 1'b1; branch_target = 32'h43;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (rom_addr !== 32'h40 || instr_valid !== 1'b0 || rom_en !== 1'b0) begin
        errors++; $display("FAIL redir_stall[%0d]: got addr=%h v=%b en=%b want addr=40 v=0 en=0",
                           i, rom_addr, instr_valid, rom_en);
      end
    end
    redirect = 1'b0; stall = 1'b0;
    step();
    checks++;
    if (obs !== slot(1'b1, 1'b0, 32'hAA, 32'h40)) begin
      errors++; $display("FAIL redir_stall_target: got %h want %h", obs, slot(1'b1, 1'b0, 32'hAA, 32'h40));
    end
  endtask

  task automatic test_out_of_range();
    logic [97:0] e;
    do_reset();
    redirect = 1'b1; branch_target = 32'h3FC;
    step();
    redirect = 1'b0;
    step();
    e = slot(1'b1, 1'b0, 32'h55FF, 32'h3FC);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL oor_last_word: got %h want %h", obs, e);
    end
    step();
    e = slot(1'b0, 1'b1, 32'h0, 32'h400);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL oor_fault: got %h want %h", obs, e);
    end
    redirect = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    e = slot(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
    checks++;
    if (obs !== e || rom_addr !== 32'h0) begin
      errors++; $display("FAIL oor_wrap: got %h addr %h want %h addr 0", obs, rom_addr, e);
    end
    step();
    e = slot(1'b1, 1'b0, 32'h11, 32'h0);
    checks++;
    if (obs !== e) begin
      errors++; $display("FAIL oor_clear: got %h want %h", obs, e);
    end
  endtask

  task automatic test_reset_midstream();
    logic [97:0] e0;
    e0 = slot(1'b0, 1'b0, 32'h0, 32'h0);
    do_reset();
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (obs !== e0 || rom_addr !== 32'h0) begin
      errors++; $display("FAIL rst_mid: got %h addr %h want %h addr 0", obs, rom_addr, e0);
    end
    step();
    step();
    checks++;
    if (obs !== slot(1'b1, 1'b0, 32'h22, 32'h4)) begin
      errors++; $display("FAIL rst_mid_resume: got %h want %h", obs, slot(1'b1, 1'b0, 32'h22, 32'h4));
    end
    stall = 1'b1;
    step();
    rst = 1'b1; redirect = 1'b1; branch_target = 32'h80;
    step();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    checks++;
    if (obs !== e0 || rom_addr !== 32'h0) begin
      errors++; $display("FAIL rst_stall: got %h addr %h want %h addr 0", obs, rom_addr, e0);
    end
    step();
    checks++;
    if (obs !== slot(1'b1, 1'b0, 32'h11, 32'h0)) begin
      errors++; $display("FAIL rst_stall_resume: got %h want %h", obs, slot(1'b1, 1'b0, 32'h11, 32'h0));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 | 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[16] = 32'hAA; mem[255] = 32'h55FF;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_out_of_range();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
